rv32im_lsu_ctrl: RTL and testbench

Sequential, parametrised successor to the combinational rv32im LSU. It accepts one load/store per transaction from the EXU and drives a request/grant/response memory bus. It generates byte enables and lane-replicated store data, and extracts plus sign/zero-extends load data. It also detects misaligned accesses and memory timeouts. It sits between the EXU and the data-memory port.

---
 rtl/rv32im_lsu_ctrl_pkg.sv | 56 +++++
 rtl/rv32im_lsu_ctrl_align.sv | 55 +++++
 rtl/rv32im_lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_rv32im_lsu_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_lsu_ctrl_pkg.sv
// Shared LSU definitions: opcode encodings, access sizes, FSM states.
// Opcode layout: [1:0] size, [2] zero-extend, [3] store.
package rv32im_lsu_ctrl_pkg;

    localparam int LSU_OPCODE_WIDTH = 4;

    typedef logic [LSU_OPCODE_WIDTH-1:0] lsu_op_t;

    localparam lsu_op_t LSU_OPCODE_LB  = 4'h0;
    localparam lsu_op_t LSU_OPCODE_LH  = 4'h1;
    localparam lsu_op_t LSU_OPCODE_LW  = 4'h2;
    localparam lsu_op_t LSU_OPCODE_LD  = 4'h3;
    localparam lsu_op_t LSU_OPCODE_LBU = 4'h4;
    localparam lsu_op_t LSU_OPCODE_LHU = 4'h5;
    localparam lsu_op_t LSU_OPCODE_LWU = 4'h6;
    localparam lsu_op_t LSU_OPCODE_SB  = 4'h8;
    localparam lsu_op_t LSU_OPCODE_SH  = 4'h9;
    localparam lsu_op_t LSU_OPCODE_SW  = 4'hA;
    localparam lsu_op_t LSU_OPCODE_SD  = 4'hB;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Doubles and LWU only exist on a 64-bit bus.
    function automatic logic op_legal(input lsu_op_t op, input logic dw64);
        case (op)
            LSU_OPCODE_LB, LSU_OPCODE_LH, LSU_OPCODE_LW,
            LSU_OPCODE_LBU, LSU_OPCODE_LHU,
            LSU_OPCODE_SB, LSU_OPCODE_SH, LSU_OPCODE_SW: op_legal = 1'b1;
            LSU_OPCODE_LD, LSU_OPCODE_SD,
            LSU_OPCODE_LWU:                              op_legal = dw64;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_size_e sz, input logic [2:0] lo);
        case (sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            SZ_W:    misaligned = |lo[1:0];
            default: misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/rv32im_lsu_ctrl_align.sv
// Lane logic: byte enables, store replication, load extract/extend.
// Purely combinational; offset is the in-bus byte position.
module lsu_align
    import rv32im_lsu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int BEW = DATA_WIDTH / 8,
    localparam int OFFS = $clog2(BEW)
) (
    input  lsu_size_e             size_i,
    input  logic                  uns_i,
    input  logic [OFFS-1:0]       off_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [BEW-1:0]        be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] sh;

    // Decode size into lane mask, replicated store data and extended load.
    always_comb begin
        sh      = rdata_i >> {off_i, 3'b000};
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        unique case (size_i)
            SZ_B: begin
                be_o    = BEW'(1) << off_i;
                wdata_o = {BEW{wdata_i[7:0]}};
                if (uns_i) rdata_o = DATA_WIDTH'(sh[7:0]);
                else       rdata_o = DATA_WIDTH'($signed(sh[7:0]));
            end
            SZ_H: begin
                be_o    = BEW'(3) << off_i;
                wdata_o = {(BEW/2){wdata_i[15:0]}};
                if (uns_i) rdata_o = DATA_WIDTH'(sh[15:0]);
                else       rdata_o = DATA_WIDTH'($signed(sh[15:0]));
            end
            SZ_W: begin
                be_o    = BEW'(15) << off_i;
                wdata_o = {(BEW/4){wdata_i[31:0]}};
                if (uns_i) rdata_o = DATA_WIDTH'(sh[31:0]);
                else       rdata_o = DATA_WIDTH'($signed(sh[31:0]));
            end
            SZ_D: begin
                be_o    = '1;
                wdata_o = wdata_i;
                rdata_o = sh;
            end
        endcase
    end

endmodule

// File: rtl/rv32im_lsu_ctrl.sv
// Sequential LSU: EXU handshake in, req/gnt/rvalid memory bus out.
// Catches misaligned/illegal accesses up front and times out stalls.
module rv32im_lsu_ctrl
    import rv32im_lsu_ctrl_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lsu_req_i,
    output logic                        lsu_ready_o,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic [ADDR_WIDTH-1:0]       addr_mem_i,
    input  logic [DATA_WIDTH-1:0]       val_memwr_i,
    output logic [DATA_WIDTH-1:0]       val_memrd_o,
    output logic                        lsu_done_o,
    output logic                        lsu_err_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [DATA_WIDTH/8-1:0]     mem_be_o,
    output logic [ADDR_WIDTH-1:0]       addr_mem_o,
    output logic [DATA_WIDTH-1:0]       val_memwr_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]       val_memrd_i
);

    localparam int   BEW  = DATA_WIDTH / 8;
    localparam int   OFFS = $clog2(BEW);
    localparam logic DW64 = (DATA_WIDTH == 64);

    lsu_state_e            state_q, state_d;
    lsu_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           cnt_q, cnt_d;

    logic                  bad_in;
    logic                  tmo_hit;
    logic                  in_req;
    logic [BEW-1:0]        be;
    logic [DATA_WIDTH-1:0] wrep;
    logic [DATA_WIDTH-1:0] rext;

    assign bad_in = !op_legal(lsu_opcode_i, DW64) ||
                    misaligned(lsu_size_e'(lsu_opcode_i[1:0]), addr_mem_i[2:0]);

    // Counter value is the number of REQ/RESP cycles already spent.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (cnt_q + 32'd1 >= TIMEOUT_CYCLES);

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .size_i  (lsu_size_e'(op_q[1:0])),
        .uns_i   (op_q[2]),
        .off_i   (addr_q[OFFS-1:0]),
        .wdata_i (wdata_q),
        .rdata_i (val_memrd_i),
        .be_o    (be),
        .wdata_o (wrep),
        .rdata_o (rext)
    );

    // Bus side is driven only while a request is outstanding.
    assign in_req      = (state_q == S_REQ);
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & op_q[3];
    assign mem_be_o    = in_req ? be : '0;
    assign val_memwr_o = in_req ? wrep : '0;
    assign addr_mem_o  = in_req ? {addr_q[ADDR_WIDTH-1:OFFS], OFFS'(0)} : '0;
    assign lsu_ready_o = (state_q == S_IDLE);
    assign lsu_done_o  = (state_q == S_DONE);
    assign lsu_err_o   = (state_q == S_DONE) & err_q;
    assign val_memrd_o = rdata_q;

    // Next-state, capture and completion logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    op_d    = lsu_opcode_i;
                    addr_d  = addr_mem_i;
                    wdata_d = val_memwr_i;
                    cnt_d   = '0;
                    err_d   = bad_in;
                    if (bad_in) begin
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_gnt_i) begin
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid_i) begin
                    err_d   = 1'b0;
                    rdata_d = op_q[3] ? '0 : rext;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rv32im_lsu_ctrl.sv
// Directed bench for rv32im_lsu_ctrl (32-bit bus, 8-cycle timeout).
// Expected values are hand-computed from the bus/extension rules.
module tb_rv32im_lsu_ctrl;
    import rv32im_lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0;
    logic        lsu_ready;
    logic [3:0]  lsu_op = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic [31:0] rd_out;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] addr_out;
    logic [31:0] wdata_out;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32im_lsu_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lsu_req_i    (lsu_req),
        .lsu_ready_o  (lsu_ready),
        .lsu_opcode_i (lsu_op),
        .addr_mem_i   (addr_in),
        .val_memwr_i  (wdata_in),
        .val_memrd_o  (rd_out),
        .lsu_done_o   (done),
        .lsu_err_o    (err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .addr_mem_o   (addr_out),
        .val_memwr_o  (wdata_out),
        .mem_gnt_i    (gnt),
        .mem_rvalid_i (rvalid),
        .val_memrd_i  (rdata_in)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with immediate gnt and rvalid (or an up-front error).
    task automatic txn(input string nm, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdv, input logic [31:0] exp_rd,
                       input logic exp_err, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_a,
                       input logic exp_we);
        lsu_req  = 1'b1;
        lsu_op   = op;
        addr_in  = a;
        wdata_in = wd;
        tick();
        lsu_req = 1'b0;
        if (exp_err) begin
            chk({nm, "/noreq"}, mem_req, 0);
            chk({nm, "/done"}, done, 1);
            chk({nm, "/err"}, err, 1);
            chk({nm, "/rd"}, rd_out, 0);
            tick();
            chk({nm, "/noreq2"}, mem_req, 0);
            chk({nm, "/ready"}, lsu_ready, 1);
            chk({nm, "/done0"}, done, 0);
        end else begin
            chk({nm, "/req"}, mem_req, 1);
            chk({nm, "/busy"}, lsu_ready, 0);
            chk({nm, "/we"}, mem_we, exp_we);
            chk({nm, "/be"}, mem_be, exp_be);
            chk({nm, "/addr"}, addr_out, exp_a);
            chk({nm, "/wd"}, wdata_out, exp_wd);
            gnt = 1'b1;
            tick();
            gnt = 1'b0;
            chk({nm, "/reqlow"}, mem_req, 0);
            chk({nm, "/nodone"}, done, 0);
            rvalid   = 1'b1;
            rdata_in = rdv;
            tick();
            rvalid = 1'b0;
            chk({nm, "/done"}, done, 1);
            chk({nm, "/err"}, err, 0);
            chk({nm, "/rd"}, rd_out, exp_rd);
            tick();
            chk({nm, "/done0"}, done, 0);
            chk({nm, "/ready"}, lsu_ready, 1);
            chk({nm, "/hold"}, rd_out, exp_rd);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst/ready", lsu_ready, 1);
        chk("rst/done", done, 0);
        chk("rst/err", err, 0);
        chk("rst/req", mem_req, 0);
        chk("rst/we", mem_we, 0);
        chk("rst/be", mem_be, 0);
        chk("rst/addr", addr_out, 0);
        chk("rst/wd", wdata_out, 0);
        chk("rst/rd", rd_out, 0);
        rst = 1'b0;
        tick();

        txn("lw0", LSU_OPCODE_LW, 32'h0, 32'h0, 32'h000CF5BD,
            32'h000CF5BD, 0, 4'hF, 32'h0, 32'h0, 0);
        txn("lb1", LSU_OPCODE_LB, 32'h1, 32'h0, 32'h000CF5BD,
            32'hFFFFFFF5, 0, 4'b0010, 32'h0, 32'h0, 0);
        txn("lbu1", LSU_OPCODE_LBU, 32'h1, 32'h0, 32'h000CF5BD,
            32'h000000F5, 0, 4'b0010, 32'h0, 32'h0, 0);
        txn("lh2", LSU_OPCODE_LH, 32'h2, 32'h0, 32'h80011234,
            32'hFFFF8001, 0, 4'b1100, 32'h0, 32'h0, 0);
        txn("lhu2", LSU_OPCODE_LHU, 32'h2, 32'h0, 32'h80011234,
            32'h00008001, 0, 4'b1100, 32'h0, 32'h0, 0);
        txn("sb103", LSU_OPCODE_SB, 32'h103, 32'hAB, 32'hDEADBEEF,
            32'h0, 0, 4'b1000, 32'hABABABAB, 32'h100, 1);
        txn("sh2", LSU_OPCODE_SH, 32'h2, 32'h1234CAFE, 32'h0,
            32'h0, 0, 4'b1100, 32'hCAFECAFE, 32'h0, 1);
        txn("lw4", LSU_OPCODE_LW, 32'h4, 32'h0, 32'h11223344,
            32'h11223344, 0, 4'hF, 32'h0, 32'h4, 0);
        txn("swmis", LSU_OPCODE_SW, 32'h2, 32'h55, 32'h0,
            32'h0, 1, 4'h0, 32'h0, 32'h0, 0);
        txn("lw8", LSU_OPCODE_LW, 32'h8, 32'h0, 32'hA5A5A5A5,
            32'hA5A5A5A5, 0, 4'hF, 32'h0, 32'h8, 0);
        txn("ld32", LSU_OPCODE_LD, 32'h0, 32'h0, 32'h0,
            32'h0, 1, 4'h0, 32'h0, 32'h0, 0);
        txn("undef", 4'h7, 32'h0, 32'h0, 32'h0,
            32'h0, 1, 4'h0, 32'h0, 32'h0, 0);
        txn("lw8b", LSU_OPCODE_LW, 32'h8, 32'h0, 32'h0BADF00D,
            32'h0BADF00D, 0, 4'hF, 32'h0, 32'h8, 0);

        // Grant withheld: error lands exactly 8 cycles after REQ entry.
        lsu_req = 1'b1;
        lsu_op  = LSU_OPCODE_LW;
        addr_in = 32'h40;
        tick();
        lsu_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("tmo/req", mem_req, 1);
            chk("tmo/nodone", done, 0);
            tick();
        end
        chk("tmo/done", done, 1);
        chk("tmo/err", err, 1);
        chk("tmo/reqlow", mem_req, 0);
        chk("tmo/rd", rd_out, 0);
        tick();
        chk("tmo/ready", lsu_ready, 1);

        // Grant after 5 stalled cycles stays within budget.
        lsu_req = 1'b1;
        lsu_op  = LSU_OPCODE_LW;
        addr_in = 32'h44;
        tick();
        lsu_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("late/req", mem_req, 1);
            tick();
        end
        chk("late/req6", mem_req, 1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("late/reqlow", mem_req, 0);
        rvalid   = 1'b1;
        rdata_in = 32'h12345678;
        tick();
        rvalid = 1'b0;
        chk("late/done", done, 1);
        chk("late/err", err, 0);
        chk("late/rd", rd_out, 32'h12345678);
        tick();

        // Reset while waiting for the response; late rvalid is dropped.
        lsu_req = 1'b1;
        lsu_op  = LSU_OPCODE_LW;
        addr_in = 32'h20;
        tick();
        lsu_req = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("rstx/resp", mem_req, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx/ready", lsu_ready, 1);
        chk("rstx/rd", rd_out, 0);
        rvalid   = 1'b1;
        rdata_in = 32'hFFFF0000;
        tick();
        rvalid = 1'b0;
        chk("rstx/nodone", done, 0);
        chk("rstx/ready2", lsu_ready, 1);
        chk("rstx/noreq", mem_req, 0);
        chk("rstx/rd2", rd_out, 0);
        tick();
        chk("rstx/nodone2", done, 0);

        txn("lwpost", LSU_OPCODE_LW, 32'hC, 32'h0, 32'hCAFEF00D,
            32'hCAFEF00D, 0, 4'hF, 32'h0, 32'hC, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
